// File: rtl/char_seg_pkg.sv
// Shared definitions for the character segment sequencer: switch roles,
// glyph bit order and the hex-to-seven-segment glyph table.
package char_seg_pkg;

   localparam int NUM_SW  = 4;
   localparam int SW_INC  = 0;
   localparam int SW_DEC  = 1;
   localparam int SW_AUTO = 2;
   localparam int SW_CLR  = 3;

   // Glyph bit positions: segment a is the msb, segment g the lsb.
   localparam int SEG_A = 6;
   localparam int SEG_G = 0;
   localparam int GLYPH_W = SEG_A - SEG_G + 1;

   function automatic logic [GLYPH_W-1:0] hex_glyph(input logic [3:0] nib);
      logic [GLYPH_W-1:0] g;
      case (nib)
         4'h0:    g = 7'b1111110;
         4'h1:    g = 7'b0110000;
         4'h2:    g = 7'b1101101;
         4'h3:    g = 7'b1111001;
         4'h4:    g = 7'b0110011;
         4'h5:    g = 7'b1011011;
         4'h6:    g = 7'b1011111;
         4'h7:    g = 7'b1110000;
         4'h8:    g = 7'b1111111;
         4'h9:    g = 7'b1111011;
         4'hA:    g = 7'b1110111;
         4'hB:    g = 7'b0011111;
         4'hC:    g = 7'b1001110;
         4'hD:    g = 7'b0111101;
         4'hE:    g = 7'b1001111;
         4'hF:    g = 7'b1000111;
         default: g = 7'b0000000;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/char_segment_sequencer_debouncer.sv
// Single push-switch debouncer: two-flop synchronizer, stability counter and
// a one-cycle pulse when the debounced state falls (switch released).
module switch_debouncer #(
   parameter int DEBOUNCE_LIMIT = 250000
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Switch,
   output logic o_Switch,
   output logic o_Release
);

   localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

   logic             meta_q;
   logic             sync_q;
   logic             stable_q, stable_d;
   logic             release_q, release_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count consecutive cycles of disagreement; flip the stable state once it persists long enough.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = {CNT_W{1'b0}};
      if (sync_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync_q;
            cnt_d    = {CNT_W{1'b0}};
         end else begin
            cnt_d    = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = {CNT_W{1'b0}};
      end
      release_d = stable_q & ~stable_d;
   end

   // Synchronizer, debounce state and release pulse registers.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         meta_q    <= 1'b0;
         sync_q    <= 1'b0;
         stable_q  <= 1'b0;
         cnt_q     <= {CNT_W{1'b0}};
         release_q <= 1'b0;
      end else begin
         meta_q    <= i_Switch;
         sync_q    <= meta_q;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         release_q <= release_d;
      end
   end

   assign o_Switch  = stable_q;
   assign o_Release = release_q;

endmodule

// File: rtl/char_segment_sequencer.sv
// Hex value sequencer driven by four debounced switches, with auto-advance
// and registered seven-segment glyph outputs for NUM_DIGITS digits.
module char_segment_sequencer
   import char_seg_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int NUM_DIGITS     = 2,
   parameter int AUTO_PERIOD    = 25000000,
   parameter bit ACTIVE_LOW     = 1'b1
) (
   input  logic                            i_Clk,
   input  logic                            i_Rst_L,
   input  logic [NUM_SW-1:0]               i_Switch,
   output logic [GLYPH_W*NUM_DIGITS-1:0]   o_Segments,
   output logic [4*NUM_DIGITS-1:0]         o_Value,
   output logic                            o_Auto,
   output logic                            o_Step
);

   localparam int VAL_W  = 4 * NUM_DIGITS;
   localparam int SEG_W  = GLYPH_W * NUM_DIGITS;
   localparam int TICK_W = $clog2(AUTO_PERIOD);
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(AUTO_PERIOD - 1);
   localparam logic [GLYPH_W-1:0] SEG_INV   = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [SEG_W-1:0]   SEG_RST   = {NUM_DIGITS{hex_glyph(4'h0) ^ SEG_INV}};

   logic [NUM_SW-1:0] sw_stable_s;
   logic [NUM_SW-1:0] sw_release_s;
   logic [NUM_SW-1:0] rel_s;
   logic              inc_s, dec_s, clr_s, tick_s;

   logic [VAL_W-1:0]  value_q, value_d;
   logic              auto_q, auto_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              step_q, step_d;
   logic [SEG_W-1:0]  segments_q, segments_d;

   for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
      switch_debouncer #(
         .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
      ) u_deb (
         .i_Clk     (i_Clk),
         .i_Rst_L   (i_Rst_L),
         .i_Switch  (i_Switch[i]),
         .o_Switch  (sw_stable_s[i]),
         .o_Release (sw_release_s[i])
      );
   end

   // Command resolution: clear beats inc/dec, opposing inc/dec cancel, manual beats the auto tick.
   always_comb begin
      rel_s  = sw_release_s & ~sw_stable_s;
      clr_s  = rel_s[SW_CLR];
      inc_s  = rel_s[SW_INC] & ~rel_s[SW_DEC];
      dec_s  = rel_s[SW_DEC] & ~rel_s[SW_INC];
      tick_s = auto_q & (tick_cnt_q == TICK_LAST);

      value_d = value_q;
      if (clr_s) begin
         value_d = {VAL_W{1'b0}};
      end else if (inc_s) begin
         value_d = value_q + VAL_W'(1);
      end else if (dec_s) begin
         value_d = value_q - VAL_W'(1);
      end else if (tick_s) begin
         value_d = value_q + VAL_W'(1);
      end else begin
         value_d = value_q;
      end

      auto_d = auto_q ^ rel_s[SW_AUTO];

      tick_cnt_d = tick_cnt_q;
      if (rel_s[SW_AUTO] || clr_s || !auto_q || tick_s) begin
         tick_cnt_d = {TICK_W{1'b0}};
      end else begin
         tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end

      step_d = (value_d != value_q);

      segments_d = segments_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         segments_d[k*GLYPH_W +: GLYPH_W] = hex_glyph(value_q[k*4 +: 4]) ^ SEG_INV;
      end
   end

   // Value, auto mode, tick counter, step pulse and glyph registers.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         value_q    <= {VAL_W{1'b0}};
         auto_q     <= 1'b0;
         tick_cnt_q <= {TICK_W{1'b0}};
         step_q     <= 1'b0;
         segments_q <= SEG_RST;
      end else begin
         value_q    <= value_d;
         auto_q     <= auto_d;
         tick_cnt_q <= tick_cnt_d;
         step_q     <= step_d;
         segments_q <= segments_d;
      end
   end

   assign o_Value    = value_q;
   assign o_Auto     = auto_q;
   assign o_Step     = step_q;
   assign o_Segments = segments_q;

endmodule
